// File: rtl/maj_fold_sched.sv
// rtl/maj_fold_sched.sv - folded majority/threshold scheduler (optional MAJ_FOLD_EARLY_EXIT_EN)
// Counts one CHUNK-bit slice of the captured vote vector per cycle and reports popcount >= THRESH.
module maj_fold_sched #(
    parameter int N      = 41,
    parameter int CHUNK  = 8,
    parameter int THRESH = (N + 1) / 2,
    localparam int NCHUNK = (N + CHUNK - 1) / CHUNK,
    localparam int CW     = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_y,
    output logic [CW-1:0] out_count,
`ifdef MAJ_FOLD_EARLY_EXIT_EN
    output logic          early_exit,
`endif
    output logic          busy
);
    localparam int IW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PW   = $clog2(CHUNK + 1);
    localparam int PADW = NCHUNK * CHUNK;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    vec_q, vec_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            early_q, early_d;

    logic [PADW-1:0] vec_pad;
    logic [CHUNK-1:0] chunk;
    logic [PW-1:0]   pc;
    logic [CW-1:0]   acc_sum;
    logic            last_chunk;

    // Bits past N in the final slice are zero padding and never count.
    always_comb begin
        vec_pad        = '0;
        vec_pad[N-1:0] = vec_q;
        chunk          = vec_pad[idx_q*CHUNK +: CHUNK];
        pc             = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pc = pc + PW'(chunk[i]);
        end
        acc_sum    = acc_q + CW'(pc);
        last_chunk = (idx_q == IW'(NCHUNK - 1));
    end

`ifdef MAJ_FOLD_EARLY_EXIT_EN
    logic [31:0] counted, remaining, acc_ext;
    logic        decided;

    // Stop once the outcome can no longer change: threshold reached, or unreachable with the bits left.
    always_comb begin
        counted   = (32'(idx_q) + 32'd1) * 32'(CHUNK);
        remaining = (counted >= 32'(N)) ? 32'd0 : (32'(N) - counted);
        acc_ext   = 32'(acc_sum);
        decided   = (acc_ext >= 32'(THRESH)) || ((acc_ext + remaining) < 32'(THRESH));
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            early_q <= early_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        early_d = early_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    vec_d   = in_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    early_d = 1'b0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (last_chunk) begin
                    state_d = S_DONE;
                end
`ifdef MAJ_FOLD_EARLY_EXIT_EN
                else if (decided) begin
                    state_d = S_DONE;
                    early_d = 1'b1;
                end
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
        out_count = (state_q == S_DONE) ? acc_q : '0;
        out_y     = (state_q == S_DONE) && (acc_q >= CW'(THRESH));
`ifdef MAJ_FOLD_EARLY_EXIT_EN
        early_exit = (state_q == S_DONE) && early_q;
`endif
    end
endmodule

// File: tb/tb_maj_fold_sched.sv
// tb/tb_maj_fold_sched.sv - randomized self-checking bench for maj_fold_sched against a popcount model
module tb_maj_fold_sched;
    localparam int N = 41, CHUNK = 8, TH = 21, NCH = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [40:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_y;
    logic [5:0]  out_count;
    logic        busy;
`ifdef MAJ_FOLD_EARLY_EXIT_EN
    logic        early_exit;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    maj_fold_sched dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_count(out_count),
`ifdef MAJ_FOLD_EARLY_EXIT_EN
        .early_exit(early_exit),
`endif
        .busy(busy)
    );

    function automatic logic [40:0] low_mask(input int m);
        logic [41:0] one = 42'd1;
        logic [41:0] t;
        t = (one << m) - 42'd1;
        return t[40:0];
    endfunction

    // Reference: edges from accept to out_valid, reported count, early-exit flag.
    function automatic void model(input logic [40:0] v, output int lat, output int cnt, output bit ee);
        lat = NCH;
        cnt = $countones(v);
        ee  = 1'b0;
`ifdef MAJ_FOLD_EARLY_EXIT_EN
        for (int k = 0; k < NCH - 1; k++) begin
            int seen, a;
            seen = ((k + 1) * CHUNK > N) ? N : (k + 1) * CHUNK;
            a = $countones(v & low_mask(seen));
            if (a >= TH || a + (N - seen) < TH) begin
                lat = k + 1;
                cnt = a;
                ee  = 1'b1;
                return;
            end
        end
`endif
    endfunction

    task automatic do_job(input logic [40:0] v, input bit pre_rdy, input int hold,
                          output int lat, output logic y, output logic [5:0] cnt, output logic ee);
        int w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        in_valid  = 1'b1;
        in_data   = v;
        out_ready = pre_rdy;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 41'({$urandom, $urandom});
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        y   = out_y;
        cnt = out_count;
`ifdef MAJ_FOLD_EARLY_EXIT_EN
        ee = early_exit;
`else
        ee = 1'b0;
`endif
        if (!pre_rdy) begin
            repeat (hold) begin @(posedge clk); #1; end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_job(input string name, input logic [40:0] v, input bit pre_rdy, input int hold);
        int lat, e_lat, e_cnt;
        bit e_ee;
        logic y, ee;
        logic [5:0] cnt;
        model(v, e_lat, e_cnt, e_ee);
        do_job(v, pre_rdy, hold, lat, y, cnt, ee);
        n_total++;
        if (y !== ($countones(v) >= TH)) $display("FAIL %s out_y got %0b want %0b v=%h", name, y, $countones(v) >= TH, v);
        else n_pass++;
        n_total++;
        if (cnt !== 6'(e_cnt)) $display("FAIL %s out_count got %0d want %0d v=%h", name, cnt, e_cnt, v);
        else n_pass++;
        n_total++;
        if (lat !== e_lat) $display("FAIL %s latency got %0d want %0d v=%h", name, lat, e_lat, v);
        else n_pass++;
        n_total++;
        if (ee !== logic'(e_ee)) $display("FAIL %s early_exit got %0b want %0b v=%h", name, ee, e_ee, v);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got %0b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got %0b want 0", out_valid); else n_pass++;
        n_total++; if (out_count !== 6'd0) $display("FAIL reset out_count got %0d want 0", out_count); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset busy got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_thresholds();
        check_job("thr21", low_mask(21), 1'b0, 0);
        check_job("thr20", low_mask(20), 1'b1, 0);
    endtask

    task automatic test_extremes();
        check_job("zero", 41'h0, 1'b0, 1);
        check_job("ones", 41'h1FF_FFFF_FFFF, 1'b0, 0);
        check_job("bit40", 41'h100_0000_0000, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        logic [40:0] v = 41'h0F0_F0F0_F0F0;
        logic y0;
        logic [5:0] c0;
        int w = 0;
        int bad = 0;
        in_valid = 1'b1; in_data = v;
        @(posedge clk); #1;
        in_data = 41'h1FF_FFFF_FFFF;
        while (!out_valid && w < 40) begin @(posedge clk); #1; w++; end
        y0 = out_y; c0 = out_count;
        n_total++; if (w !== 6) $display("FAIL bp latency got %0d want 6", w); else n_pass++;
        n_total++; if (c0 !== 6'd20 || y0 !== 1'b0) $display("FAIL bp result got %0d/%0b want 20/0", c0, y0); else n_pass++;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_y !== y0 || out_count !== c0 || in_ready !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL bp hold unstable cycles got %0d want 0", bad); else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL bp release got valid=%0b ready=%0b busy=%0b want 0/1/0", out_valid, in_ready, busy);
        else n_pass++;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL bp stray accept busy got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        in_valid = 1'b1; in_data = 41'h1FF_FFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL midrst abort got busy=%0b valid=%0b want 0/0", busy, out_valid); else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; if (out_valid) seen++; end
        n_total++; if (seen !== 0) $display("FAIL midrst out_valid pulses got %0d want 0", seen); else n_pass++;
        check_job("after_rst", 41'h155_5555_5555, 1'b0, 0);
    endtask

`ifdef MAJ_FOLD_EARLY_EXIT_EN
    task automatic test_early_exit();
        check_job("ee_24", low_mask(24), 1'b0, 0);
        check_job("ee_zero", 41'h0, 1'b0, 0);
    endtask
`endif

    task automatic test_back_to_back();
        for (int j = 0; j < 2000; j++) begin
            logic [40:0] v;
            if (j % 2 == 0) begin
                v = 41'({$urandom, $urandom});
            end else begin
                int k = $urandom_range(16, 26);
                v = '0;
                while ($countones(v) < k) v[$urandom_range(0, 40)] = 1'b1;
            end
            check_job("rand", v, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_thresholds();
        test_extremes();
        test_backpressure();
        test_reset_mid();
`ifdef MAJ_FOLD_EARLY_EXIT_EN
        test_early_exit();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
